// File: rtl/prog_sequencer.sv
// prog_sequencer: fetches instructions from a 1-cycle ROM and runs them on the control unit via Run/Done.
// Optional single-step mode (Step/Paused ports, PAUSE state) enabled by defining SEQ_SINGLE_STEP_EN.
module prog_sequencer #(
    parameter int PC_W    = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Start,
    output logic [PC_W-1:0]   rom_addr,
    input  logic [7:0]        rom_data,
    output logic              Run,
    output logic [1:0]        Fun,
    output logic [1:0]        Rx,
    output logic [1:0]        Ry,
    input  logic              Done,
    output logic [DATA_W-1:0] Din,
    output logic              Busy,
    output logic              Halted,
    output logic              Error
`ifdef SEQ_SINGLE_STEP_EN
    ,
    input  logic              Step,
    output logic              Paused
`endif
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, FETCH_IMM, LATCH_IMM, ISSUE,
        WAIT_HI, WAIT_LO, NEXT, HALTED, ERROR, PAUSE
    } state_t;

    state_t            r_state, w_next;
    logic [PC_W-1:0]   r_pc;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
    logic [1:0]        r_fun, r_rx, r_ry;
    logic [DATA_W-1:0] r_din;
    logic              r_halt, r_wrap;
    logic              w_accept, w_load, w_to, w_end, w_adv, w_count;

    assign w_accept = (r_state == IDLE || r_state == HALTED || r_state == ERROR) && Start;
    assign w_load   = rom_data[7:6] == 2'b00;
    assign w_cnt_nx = r_cnt + 1'b1;
    assign w_to     = w_cnt_nx == CNT_W'(TIMEOUT);
    // r_wrap marks a Load at the last address whose immediate came from address 0
    assign w_end    = r_halt | (&r_pc) | r_wrap;
    assign w_count  = (r_state == WAIT_HI && !Done) || (r_state == WAIT_LO && Done);
`ifdef SEQ_SINGLE_STEP_EN
    assign w_adv    = r_state == PAUSE && Step;
`else
    assign w_adv    = r_state == NEXT && !w_end;
`endif
    assign rom_addr = r_pc;
    assign Fun      = r_fun;
    assign Rx       = r_rx;
    assign Ry       = r_ry;
    assign Din      = r_din;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, HALTED, ERROR: w_next = Start ? FETCH : r_state;
            FETCH:               w_next = DECODE;
            DECODE:              w_next = w_load ? FETCH_IMM : ISSUE;
            FETCH_IMM:           w_next = LATCH_IMM;
            LATCH_IMM:           w_next = ISSUE;
            ISSUE:               w_next = WAIT_HI;
            WAIT_HI:             w_next = Done ? WAIT_LO : (w_to ? ERROR : WAIT_HI);
            WAIT_LO:             w_next = !Done ? NEXT : (w_to ? ERROR : WAIT_LO);
`ifdef SEQ_SINGLE_STEP_EN
            NEXT:                w_next = w_end ? HALTED : PAUSE;
            PAUSE:               w_next = Step ? FETCH : PAUSE;
`else
            NEXT:                w_next = w_end ? HALTED : FETCH;
`endif
            default:             w_next = IDLE;
        endcase
    end

    always_comb begin
        Run    = r_state == ISSUE;
        Busy   = !(r_state == IDLE || r_state == HALTED || r_state == ERROR);
        Halted = r_state == HALTED;
        Error  = r_state == ERROR;
`ifdef SEQ_SINGLE_STEP_EN
        Paused = r_state == PAUSE;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc   <= '0;
            r_cnt  <= '0;
            r_fun  <= '0;
            r_rx   <= '0;
            r_ry   <= '0;
            r_din  <= '0;
            r_halt <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_cnt <= w_count ? w_cnt_nx : '0;
            if (w_accept) begin
                r_pc   <= '0;
                r_wrap <= 1'b0;
            end else if (r_state == DECODE && w_load) begin
                r_pc   <= r_pc + 1'b1;
                r_wrap <= &r_pc;
            end else if (w_adv) begin
                r_pc   <= r_pc + 1'b1;
            end
            if (r_state == DECODE) begin
                r_fun  <= rom_data[7:6];
                r_rx   <= rom_data[5:4];
                r_ry   <= rom_data[3:2];
                r_halt <= rom_data[1];
            end
            if (r_state == LATCH_IMM) r_din <= rom_data[DATA_W-1:0];
        end
    end
endmodule
